if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the pipelined core. It owns the program counter, issues word fetches to instruction memory over a req/ready handshake, and hands `{pc, instr}` to the IF/ID pipeline register via that register's `Select` load-enable. It holds its output under hazard stalls and discards in-flight fetches on a branch/jump redirect, loading a NOP bubble into IF/ID.

## Interface
- `XLEN`, 32, datapath and address width.
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `clk` in 1, system clock; all state updates on the rising edge.
- `rst` in 1, asynchronous, active-low reset.
- `imem_req` out 1, fetch request; held high until accepted.
- `imem_addr` out XLEN, word-aligned fetch address; stable while `imem_req && !imem_ready`.
- `imem_ready` in 1, a transfer completes in any cycle with `imem_req && imem_ready`.
- `imem_rdata` in XLEN, instruction word, valid only in the transfer cycle.
- `stall_i` in 1, hazard unit: hold IF/ID contents this cycle.
- `redirect_i` in 1, branch/jump taken from EX: one-cycle pulse.
- `redirect_pc_i` in XLEN, redirect target; bits [1:0] are ignored and forced to 0.
- `ifid_load` out 1, drives the IF/ID register `Select`: 1 = load payload this edge.
- `ifid_payload` out 2*XLEN, `{pc, instr}`, with pc in the upper half.

## Operation
- States:
  - `BOOT`: one cycle after reset release, no request.
  - `FETCH`: request outstanding.
  - `HOLD`: word captured, downstream stalled.
  - `DISCARD`: redirect arrived mid-request.
- `BOOT` → `FETCH` unconditionally.
- `FETCH`, transfer, no stall, no redirect: `ifid_load=1`, payload `{pc, imem_rdata}`, pc += 4, stay in `FETCH`. The next request issues in the following cycle.
- `FETCH`, transfer with `stall_i=1`: capture `{pc, rdata}` into the hold buffer, `ifid_load=0`, pc += 4, go to `HOLD`.
- `HOLD`:
  - `imem_req=0`.
  - When `stall_i` drops, `ifid_load=1` with the buffered payload, then go to `FETCH`.
- Redirect has priority over stall in every state. Whenever `redirect_i=1`, the following happens in that cycle:
  - `ifid_load=1`, payload `{redirect_pc_i, 32'h0000_0013}` (NOP bubble).
  - pc ← `redirect_pc_i`.
  - The hold buffer is cleared.
- Redirect in `FETCH` with a transfer in the same cycle: the returned word is dropped, next state `FETCH` at the new pc.
- Redirect in `FETCH` without a transfer: go to `DISCARD`. `imem_req` and the old `imem_addr` are held until `imem_ready`, that word is dropped, then go to `FETCH` at the new pc.
- Redirect in `DISCARD`: update pc to the newest target and stay in `DISCARD`.
- Redirect in `HOLD` or `BOOT`: go to `FETCH` at the new pc.
- pc arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (async assert, sync release) puts the outputs in these states:
  - `imem_req=0`, `imem_addr=RESET_PC`, `ifid_load=0`, `ifid_payload={RESET_PC, 32'h13}`.
  - pc=`RESET_PC`, state `BOOT`.
- First `imem_req=1` occurs in the 2nd cycle after reset deassertion.
- With zero-wait memory (`imem_ready` tied high), steady state is one fetch per 2 cycles: request cycle, then pc-update cycle. `imem_req` is registered; no combinational path from `imem_ready` to `imem_req`.
- `ifid_load` and `ifid_payload` are combinational from state and inputs, valid in the same cycle as the transfer or redirect.
- Reset asserted mid-request abandons the request immediately; memory must tolerate `imem_req` dropping.

## Structure
- Shared package `core_pkg` holds:
  - `NOP_INSTR = 32'h0000_0013`.
  - The fetch state enum (`BOOT`, `FETCH`, `HOLD`, `DISCARD`).
  - The `XLEN` default.
- Sub-module `if_hold_buf`: a 2*XLEN register with load and clear inputs, async active-low reset. The top level contains the FSM and pc logic only.

## Test plan
- Reset release, `imem_ready=1`: first `imem_addr=0`, IF/ID receives `{0, rdata}`, `{4, rdata}`, `{8, rdata}` on successive loads.
- Wait states: `imem_ready` low for 3 cycles at addr 0x10 → `imem_addr` stays 0x10 and `ifid_load` stays 0 until the transfer.
- `stall_i=1` during the transfer at 0x20, held 4 cycles → no load and `imem_req=0` during the stall; on release the load is `{0x20, word}`, then the next fetch is at 0x24.
- `redirect_i` with target 0x100 while a fetch at 0x40 is waiting → NOP bubble `{0x100, 0x13}` loaded, word at 0x40 dropped, next address 0x100.
- `redirect_i` and `stall_i` in the same cycle as a transfer → bubble loaded, no `HOLD`; fetch resumes at the target.
- Async reset mid-`HOLD` → all outputs return to reset values with no clock edge; restart at `RESET_PC`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline.
// Contents: datapath width default, the NOP used for pipeline bubbles,
// and the state encoding of the instruction-fetch FSM.
package core_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// Hold buffer for a fetched {pc, instr} pair while the pipeline is stalled.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   load        - capture d on this edge
//   clr         - clear to zero on this edge (wins over load)
//   d, q        - 2*XLEN payload in / registered payload out
module if_hold_buf
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [2*XLEN-1:0] d,
  output logic [2*XLEN-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the pc, issues word fetches over a
// req/ready handshake and loads {pc, instr} into the IF/ID register.
//
// state   | meaning
// --------+---------------------------------------------------------
// BOOT    | first cycle after reset release, no request
// FETCH   | fetching; imem_req high = request out, low = pc-update cycle
// HOLD    | word captured in hold buffer, downstream stalled
// DISCARD | redirect arrived mid-request; drop the word when it returns
//
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata - instruction memory handshake
//   stall_i                  - hold IF/ID contents this cycle
//   redirect_i/redirect_pc_i - taken branch/jump and its target
//   ifid_load, ifid_payload  - IF/ID load enable and {pc, instr}
module if_fetch_stage
  import core_pkg::*;
#(
  parameter int unsigned  XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              ifid_load,
  output logic [2*XLEN-1:0] ifid_payload
);

  localparam logic [XLEN-1:0] NOP_X = XLEN'(NOP_INSTR);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic              hb_load, hb_clr;
  logic [2*XLEN-1:0] hb_q;
  logic              xfer;
  logic [XLEN-1:0]   tgt;

  assign xfer      = req_q && imem_ready;
  assign tgt       = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign imem_req  = req_q;
  // Separate from pc so the old address is held in DISCARD.
  assign imem_addr = addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    req_d        = req_q;
    ifid_load    = 1'b0;
    ifid_payload = {pc_q, NOP_X};
    hb_load      = 1'b0;
    hb_clr       = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end else if (xfer) begin
          req_d = 1'b0;
          pc_d  = pc_q + XLEN'(4);
          if (stall_i) begin
            hb_load = 1'b1;
            state_d = HOLD;
          end else begin
            ifid_load    = 1'b1;
            ifid_payload = {pc_q, imem_rdata};
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          ifid_load    = 1'b1;
          ifid_payload = hb_q;
          state_d      = FETCH;
        end
      end
      DISCARD: begin
        if (xfer) begin
          req_d   = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    // Redirect overrides everything above, including a pending stall.
    if (redirect_i) begin
      ifid_load    = 1'b1;
      ifid_payload = {tgt, NOP_X};
      pc_d         = tgt;
      hb_load      = 1'b0;
      hb_clr       = 1'b1;
      case (state_q)
        BOOT: begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = tgt;
        end
        FETCH: begin
          if (!req_q) begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = tgt;
          end else if (xfer) begin
            state_d = FETCH;
            req_d   = 1'b0;
          end else begin
            state_d = DISCARD;
            req_d   = 1'b1;
            addr_d  = addr_q;
          end
        end
        HOLD: begin
          state_d = FETCH;
          req_d   = 1'b0;
        end
        default: ; // DISCARD keeps waiting for the stale word
      endcase
    end
  end

  if_hold_buf #(.XLEN(XLEN)) u_hold_buf (
    .clk  (clk),
    .rst  (rst),
    .load (hb_load),
    .clr  (hb_clr),
    .d    ({pc_q, imem_rdata}),
    .q    (hb_q)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ifid_load;
  logic [63:0] ifid_payload;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = imem_req ? word_of(imem_addr) : 32'hBAD0_BAD0;

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ifid_load     (ifid_load),
    .ifid_payload  (ifid_payload)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] a);
    exp_q.push_back({a, word_of(a)});
  endtask

  // Returns #1 after the edge that starts a request cycle at address a.
  task automatic wait_for(input logic [31:0] a, input string name);
    int n = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && n < 60) begin
      tick();
      n++;
    end
    chk(name, {63'd0, (imem_req === 1'b1 && imem_addr === a)}, 64'd1);
  endtask

  // Scoreboard monitor: every IF/ID load must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ifid_load === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load", ifid_payload, 64'hx);
        end else begin
          chk("ifid_payload", ifid_payload, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b0; imem_ready = 1'b1; stall_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    #3;
    chk("rst_req",     {63'd0, imem_req},  64'd0);
    chk("rst_addr",    {32'd0, imem_addr}, 64'd0);
    chk("rst_load",    {63'd0, ifid_load}, 64'd0);
    chk("rst_payload", ifid_payload, {32'd0, NOP});
    @(posedge clk); #1;
    rst = 1'b1;
    for (int a = 0; a < 16; a += 4) push_word(a);
    chk("boot_no_req", {63'd0, imem_req}, 64'd0);
    tick();
    chk("first_req",  {63'd0, imem_req},  64'd1);
    chk("first_addr", {32'd0, imem_addr}, 64'd0);

    // Wait states at 0x10
    wait_for(32'h10, "reach_10");
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_addr", {32'd0, imem_addr}, 64'h10);
      chk("ws_load", {63'd0, ifid_load}, 64'd0);
    end
    imem_ready = 1'b1;
    for (int a = 16; a < 32; a += 4) push_word(a);

    // Stall during transfer at 0x20
    wait_for(32'h20, "reach_20");
    stall_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_req",  {63'd0, imem_req},  64'd0);
      chk("stall_load", {63'd0, ifid_load}, 64'd0);
      tick();
    end
    push_word(32'h20);
    stall_i = 1'b0;
    #1;
    chk("release_load", {63'd0, ifid_load}, 64'd1);
    tick();
    for (int a = 32'h24; a < 32'h40; a += 4) push_word(a);
    wait_for(32'h24, "after_stall_24");

    // Redirect while fetch at 0x40 waits
    wait_for(32'h40, "reach_40");
    imem_ready = 1'b0;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    exp_q.push_back({32'h100, NOP});
    tick();
    redirect_i = 1'b0;
    chk("discard_req",  {63'd0, imem_req},  64'd1);
    chk("discard_addr", {32'd0, imem_addr}, 64'h40);
    imem_ready = 1'b1;
    tick();
    push_word(32'h100); push_word(32'h104);
    wait_for(32'h100, "redir_target");

    // Redirect + stall together with a transfer at 0x108 (target misaligned)
    wait_for(32'h108, "reach_108");
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h203;
    exp_q.push_back({32'h200, NOP});
    tick();
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("no_hold_req_gap", {63'd0, imem_req}, 64'd0);
    tick();
    chk("resume_req",  {63'd0, imem_req},  64'd1);
    chk("resume_addr", {32'd0, imem_addr}, 64'h200);
    push_word(32'h200);

    // Async reset in the middle of HOLD
    wait_for(32'h204, "reach_204");
    stall_i = 1'b1;
    tick();
    chk("hold_req", {63'd0, imem_req}, 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_req",     {63'd0, imem_req},  64'd0);
    chk("arst_addr",    {32'd0, imem_addr}, 64'd0);
    chk("arst_load",    {63'd0, ifid_load}, 64'd0);
    chk("arst_payload", ifid_payload, {32'd0, NOP});
    stall_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    push_word(32'h0);
    exp_q.push_back({32'hFFFF_FFFC, NOP});
    push_word(32'hFFFF_FFFC);
    push_word(32'h0);
    wait_for(32'h0, "restart_0");
    tick();
    chk("gap_req", {63'd0, imem_req}, 64'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    wait_for(32'hFFFF_FFFC, "reach_top");
    tick();
    wait_for(32'h0, "wrap_to_0");
    tick(); tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
